decay_sweep_engine: RTL and testbench

//  Multi-channel membrane-potential store with tick-driven decay.

---
 rtl/decay_pkg.sv | 26 ++
 rtl/decay_msb_enc.sv | 15 +
 rtl/decay_sweep_engine.sv | 135 +++++++++++++
 tb/tb_decay_sweep_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decay_pkg.sv
// Shared types and defaults for the decay sweep engine.
// No logic beyond a combinational highest-set-bit helper.
package decay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } decay_state_t;

    localparam int DEF_W    = 14;
    localparam int DEF_FRAC = 8;
    localparam int DEF_KW   = 8;
    localparam int DEF_NCH  = 16;

    // Index of the highest set bit; zero input maps to 0.
    function automatic logic [4:0] msb_index(input logic [31:0] v);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) p = 5'(i);
        end
        return p;
    endfunction

endpackage

// File: rtl/decay_msb_enc.sv
// W-bit priority encoder giving the highest set bit index (0 for zero input).
// Purely combinational, no backpressure.
module decay_msb_enc
    import decay_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  v_i,
    output logic [PW-1:0] p_o
);

    assign p_o = PW'(msb_index(32'(v_i)));

endmodule

// File: rtl/decay_sweep_engine.sv
// Channel potential store: valid/ready accumulate in IDLE, tick sweeps all channels through a 2-stage decay.
// Sweep takes NCH+1 cycles tick-to-done; in_ready low while sweeping. DECAY_SAT_EN selects clamping vs wrap.
module decay_sweep_engine
    import decay_pkg::*;
#(
    parameter int            W       = DEF_W,
    parameter int            FRAC    = DEF_FRAC,
    parameter int            NCH     = DEF_NCH,
    parameter int            KW      = DEF_KW,
    parameter logic [KW-1:0] DECAY_K = KW'(1),
    localparam int           CW      = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [CW-1:0] in_ch_i,
    input  logic [W-1:0]  in_weight_i,
    input  logic [CW-1:0] rd_ch_i,
    output logic [W-1:0]  rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          tick_ovr_o
);

    localparam int PW = $clog2(W);

    decay_state_t  state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          s1_load;

    logic [W-1:0]  pot_q [NCH];
    logic          s1_vld_q;
    logic [CW-1:0] s1_ch_q;
    logic [W-1:0]  s1_v_q;
    logic [PW-1:0] s1_p_q;
    logic [W-1:0]  rd_data_q;
    logic          done_q;
    logic          tick_ovr_q;

    logic [W-1:0]  rd_v;
    logic [PW-1:0] rd_p;
    logic [W-1:0]  sub;
    logic [W-1:0]  dec_dat;
    logic [W-1:0]  acc_dat;
    logic          acc_fire;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_dat;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        s1_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                s1_load = 1'b1;
                idx_d   = idx_q + CW'(1);
                if (idx_q == CW'(NCH - 1)) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o = (state_q == IDLE);
    assign busy_o     = !in_ready_o;
    assign acc_fire   = in_valid_i && in_ready_o;

    // Stage 1: fetch the channel under the sweep index and find its magnitude.
    assign rd_v = pot_q[idx_q];

    decay_msb_enc #(.W(W), .PW(PW)) u_msb (
        .v_i (rd_v),
        .p_o (rd_p)
    );

    // Stage 2: subtract (K << p) >> FRAC, formed wide enough that K<<p never overflows.
    assign sub = W'((((W + KW))'(DECAY_K) << s1_p_q) >> FRAC);

`ifdef DECAY_SAT_EN
    logic [W:0] acc_sum;
    assign acc_sum = {1'b0, pot_q[in_ch_i]} + {1'b0, in_weight_i};
    assign acc_dat = acc_sum[W] ? '1 : acc_sum[W-1:0];
    assign dec_dat = (sub > s1_v_q) ? '0 : (s1_v_q - sub);
`else
    assign acc_dat = pot_q[in_ch_i] + in_weight_i;
    assign dec_dat = s1_v_q - sub;
`endif

    // Write-backs and accumulates never overlap: accumulates only fire in IDLE.
    assign wr_en  = s1_vld_q || acc_fire;
    assign wr_ch  = s1_vld_q ? s1_ch_q : in_ch_i;
    assign wr_dat = s1_vld_q ? dec_dat : acc_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_ch_q    <= '0;
            s1_v_q     <= '0;
            s1_p_q     <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            tick_ovr_q <= 1'b0;
            for (int i = 0; i < NCH; i++) pot_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            s1_vld_q   <= s1_load;
            done_q     <= (state_q == DRAIN);
            tick_ovr_q <= tick_i && busy_o;
            if (s1_load) begin
                s1_ch_q <= idx_q;
                s1_v_q  <= rd_v;
                s1_p_q  <= rd_p;
            end
            if (wr_en) pot_q[wr_ch] <= wr_dat;
            rd_data_q <= (wr_en && (wr_ch == rd_ch_i)) ? wr_dat : pot_q[rd_ch_i];
        end
    end

    assign rd_data_o  = rd_data_q;
    assign done_o     = done_q;
    assign tick_ovr_o = tick_ovr_q;

endmodule

// File: tb/tb_decay_sweep_engine.sv
// Three engines (K=1, K=4, K=0x200 with KW=10) share stimulus and are checked against an arithmetic model.
module tb_decay_sweep_engine;

    localparam int W    = 14;
    localparam int FRAC = 8;
    localparam int NCH  = 16;
    localparam longint unsigned MODW = longint'(1) << W;

    logic clk = 1'b0;
    logic rst_n;
    logic tick, in_valid;
    logic [3:0]  in_ch, rd_ch;
    logic [13:0] in_weight;
    logic [2:0]  in_ready, busy, done, tick_ovr;
    logic [13:0] rd_d [3];

    int tests = 0;
    int fails = 0;
    int unsigned KS [3] = '{1, 4, 512};
    int unsigned pm [3][NCH];

    always #5 clk = ~clk;

    decay_sweep_engine #(.W(W), .FRAC(FRAC), .NCH(NCH), .KW(8), .DECAY_K(8'd1)) u_k1 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .in_ch_i(in_ch), .in_weight_i(in_weight), .rd_ch_i(rd_ch), .rd_data_o(rd_d[0]),
        .busy_o(busy[0]), .done_o(done[0]), .tick_ovr_o(tick_ovr[0]));

    decay_sweep_engine #(.W(W), .FRAC(FRAC), .NCH(NCH), .KW(8), .DECAY_K(8'd4)) u_k4 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .in_ch_i(in_ch), .in_weight_i(in_weight), .rd_ch_i(rd_ch), .rd_data_o(rd_d[1]),
        .busy_o(busy[1]), .done_o(done[1]), .tick_ovr_o(tick_ovr[1]));

    decay_sweep_engine #(.W(W), .FRAC(FRAC), .NCH(NCH), .KW(10), .DECAY_K(10'h200)) u_kb (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
        .in_ch_i(in_ch), .in_weight_i(in_weight), .rd_ch_i(rd_ch), .rd_data_o(rd_d[2]),
        .busy_o(busy[2]), .done_o(done[2]), .tick_ovr_o(tick_ovr[2]));

    // Reference arithmetic: floor(log2 v), then K*2^p / 2^FRAC reduced mod 2^W.
    function automatic int unsigned m_decay(input int unsigned v, input int unsigned k);
        int unsigned p = 0;
        longint unsigned sub;
        while (p < W - 1 && (longint'(1) << (p + 1)) <= longint'(v)) p++;
        sub = ((longint'(k) * (longint'(1) << p)) / (longint'(1) << FRAC)) % MODW;
`ifdef DECAY_SAT_EN
        return (sub > longint'(v)) ? 0 : int'(longint'(v) - sub);
`else
        return int'((longint'(v) + MODW - sub) % MODW);
`endif
    endfunction

    function automatic int unsigned m_acc(input int unsigned v, input int unsigned w);
        longint unsigned s = longint'(v) + longint'(w);
`ifdef DECAY_SAT_EN
        return (s >= MODW) ? int'(MODW - 1) : int'(s);
`else
        return int'(s % MODW);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < NCH; c++) pm[d][c] = 0;
    endtask

    task automatic acc(input int ch, input int unsigned w);
        in_valid  = 1'b1;
        in_ch     = 4'(ch);
        in_weight = 14'(w);
        step();
        in_valid  = 1'b0;
        for (int d = 0; d < 3; d++) pm[d][ch] = m_acc(pm[d][ch], w & 32'h3FFF);
    endtask

    // Drives one tick (optionally with a same-cycle accumulate) and observes the sweep.
    task automatic run_sweep(input bit with_add, input int ach, input int unsigned aw,
                             input int ovr_at, input bit stop_at_done,
                             output int ncyc, output int ndone, output int novr,
                             output logic ovr_rdy, output logic [2:0][13:0] rd_done);
        rd_ch = 4'(NCH - 1);
        tick  = 1'b1;
        if (with_add) begin
            in_valid  = 1'b1;
            in_ch     = 4'(ach);
            in_weight = 14'(aw);
            for (int d = 0; d < 3; d++) pm[d][ach] = m_acc(pm[d][ach], aw & 32'h3FFF);
        end
        step();
        tick     = 1'b0;
        in_valid = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < NCH; c++) pm[d][c] = m_decay(pm[d][c], KS[d]);
        ncyc = 0; ndone = 0; novr = 0; ovr_rdy = 1'b1; rd_done = '0;
        for (int n = 1; n <= 24; n++) begin
            if (n == ovr_at) begin
                tick      = 1'b1;
                in_valid  = 1'b1;
                in_ch     = 4'($urandom_range(0, NCH - 1));
                in_weight = 14'($urandom);
                ovr_rdy   = in_ready[0];
            end
            step();
            tick     = 1'b0;
            in_valid = 1'b0;
            novr += int'(tick_ovr[0]);
            if (done[0]) begin
                ndone++;
                if (ncyc == 0) begin
                    ncyc    = n;
                    rd_done = {rd_d[2], rd_d[1], rd_d[0]};
                end
                if (stop_at_done) break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; in_valid = 1'b0; in_ch = '0; in_weight = '0; rd_ch = '0;
        model_clear();
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (rd_d[d] !== 14'h0 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
                tick_ovr[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
                fails++;
                $display("FAIL reset dut%0d rd=%h busy=%b done=%b ovr=%b rdy=%b exp 0/0/0/0/1",
                         d, rd_d[d], busy[d], done[d], tick_ovr[d], in_ready[d]);
            end
        end
        rst_n = 1'b1;
        step();
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 4'(c);
            step();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (rd_d[d] !== 14'h0) begin
                    fails++;
                    $display("FAIL reset_pot dut%0d ch%0d got %h exp 0000", d, c, rd_d[d]);
                end
            end
        end
    endtask

    task automatic test_spec_vectors();
        int ncyc, ndone, novr;
        logic ovr_rdy;
        logic [2:0][13:0] rdn;
        logic [13:0] exp_v;
        acc(3, 'h0300);
        acc(5, 'h0080);
        acc(0, 'h0001);
        acc(2, 'h3FF0);
        acc(2, 'h0020);
        rd_ch = 4'd2;
        step();
`ifdef DECAY_SAT_EN
        exp_v = 14'h3FFF;
`else
        exp_v = 14'h0010;
`endif
        tests++;
        if (rd_d[0] !== exp_v) begin
            fails++;
            $display("FAIL acc_limit ch2 got %h exp %h", rd_d[0], exp_v);
        end
        run_sweep(1'b0, 0, 0, -1, 1'b0, ncyc, ndone, novr, ovr_rdy, rdn);
        tests++;
        if (ncyc !== NCH + 1 || ndone !== 1 || novr !== 0) begin
            fails++;
            $display("FAIL sweep_timing cyc=%0d done=%0d ovr=%0d exp %0d/1/0", ncyc, ndone, novr, NCH + 1);
        end
        rd_ch = 4'd3; step();
        tests++;
        if (rd_d[0] !== 14'h02FE) begin
            fails++;
            $display("FAIL k1_ch3 got %h exp 02fe", rd_d[0]);
        end
        rd_ch = 4'd5; step();
        tests++;
        if (rd_d[0] !== 14'h0080 || rd_d[1] !== 14'h007E) begin
            fails++;
            $display("FAIL ch5 got k1=%h k4=%h exp 0080/007e", rd_d[0], rd_d[1]);
        end
        rd_ch = 4'd0; step();
`ifdef DECAY_SAT_EN
        exp_v = 14'h0000;
`else
        exp_v = 14'h3FFF;
`endif
        tests++;
        if (rd_d[2] !== exp_v) begin
            fails++;
            $display("FAIL kbig_ch0 got %h exp %h", rd_d[2], exp_v);
        end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 4'(c);
            step();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (rd_d[d] !== 14'(pm[d][c])) begin
                    fails++;
                    $display("FAIL vec_pot dut%0d ch%0d got %h exp %h", d, c, rd_d[d], 14'(pm[d][c]));
                end
            end
        end
    endtask

    task automatic test_random();
        int ncyc, ndone, novr;
        logic ovr_rdy;
        logic [2:0][13:0] rdn;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < int'($urandom_range(1, 8)); a++)
                acc(int'($urandom_range(0, NCH - 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(14'h3000, 14'h3FFF) : $urandom_range(0, 14'h0FFF));
            acc(NCH - 1, $urandom_range(0, 14'h3FFF));
            run_sweep(1'($urandom_range(0, 1)), int'($urandom_range(0, NCH - 1)), $urandom_range(0, 14'h3FFF),
                      -1, 1'b0, ncyc, ndone, novr, ovr_rdy, rdn);
            tests++;
            if (ncyc !== NCH + 1 || ndone !== 1) begin
                fails++;
                $display("FAIL rnd_timing r%0d cyc=%0d done=%0d exp %0d/1", r, ncyc, ndone, NCH + 1);
            end
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (rdn[d] !== 14'(pm[d][NCH - 1])) begin
                    fails++;
                    $display("FAIL write_first r%0d dut%0d got %h exp %h", r, d, rdn[d], 14'(pm[d][NCH - 1]));
                end
            end
            for (int c = 0; c < NCH; c++) begin
                rd_ch = 4'(c);
                step();
                for (int d = 0; d < 3; d++) begin
                    tests++;
                    if (rd_d[d] !== 14'(pm[d][c])) begin
                        fails++;
                        $display("FAIL rnd_pot r%0d dut%0d ch%0d got %h exp %h", r, d, c, rd_d[d], 14'(pm[d][c]));
                    end
                end
            end
        end
    endtask

    task automatic test_overrun();
        int ncyc, ndone, novr;
        logic ovr_rdy;
        logic [2:0][13:0] rdn;
        acc(7, 'h1234);
        run_sweep(1'b0, 0, 0, 4, 1'b0, ncyc, ndone, novr, ovr_rdy, rdn);
        tests++;
        if (novr !== 1 || ovr_rdy !== 1'b0 || ndone !== 1 || ncyc !== NCH + 1) begin
            fails++;
            $display("FAIL overrun ovr=%0d rdy=%b done=%0d cyc=%0d exp 1/0/1/%0d", novr, ovr_rdy, ndone, ncyc, NCH + 1);
        end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 4'(c);
            step();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (rd_d[d] !== 14'(pm[d][c])) begin
                    fails++;
                    $display("FAIL ovr_pot dut%0d ch%0d got %h exp %h", d, c, rd_d[d], 14'(pm[d][c]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ncyc, ndone, novr, ncyc2, ndone2, novr2;
        logic ovr_rdy;
        logic [2:0][13:0] rdn;
        acc(4, 'h2000);
        run_sweep(1'b0, 0, 0, -1, 1'b1, ncyc, ndone, novr, ovr_rdy, rdn);
        run_sweep(1'b1, 4, 'h0100, -1, 1'b0, ncyc2, ndone2, novr2, ovr_rdy, rdn);
        tests++;
        if (ncyc !== NCH + 1 || ncyc2 !== NCH + 1 || ndone2 !== 1 || novr + novr2 !== 0) begin
            fails++;
            $display("FAIL b2b cyc=%0d/%0d done2=%0d ovr=%0d exp %0d/%0d/1/0", ncyc, ncyc2, ndone2, novr + novr2, NCH + 1, NCH + 1);
        end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 4'(c);
            step();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (rd_d[d] !== 14'(pm[d][c])) begin
                    fails++;
                    $display("FAIL b2b_pot dut%0d ch%0d got %h exp %h", d, c, rd_d[d], 14'(pm[d][c]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ndone = 0;
        acc(9, 'h0555);
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (busy[d] !== 1'b0 || done[d] !== 1'b0 || rd_d[d] !== 14'h0 || in_ready[d] !== 1'b1) begin
                fails++;
                $display("FAIL mid_reset dut%0d busy=%b done=%b rd=%h rdy=%b exp 0/0/0000/1",
                         d, busy[d], done[d], rd_d[d], in_ready[d]);
            end
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            ndone += int'(done[0]) + int'(done[1]) + int'(done[2]);
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL mid_reset_done got %0d pulses exp 0", ndone);
        end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = 4'(c);
            step();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (rd_d[d] !== 14'(pm[d][c])) begin
                    fails++;
                    $display("FAIL mid_reset_pot dut%0d ch%0d got %h exp %h", d, c, rd_d[d], 14'(pm[d][c]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_overrun();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
